cic_rate_ctrl: RTL and testbench

- Run-time controller that owns the `decimation` input of one `cic` decimator instance.
- Accepts rate-change requests from the register/command interface through a valid/ready handshake, and clamps each value to the legal range.
- Applies a new rate only on a CIC output boundary, where the CIC phase counter is 0. This prevents the phase counter from running past a reduced terminal count.
- Suppresses the CIC outputs that are corrupt while the comb chain and gain settle, and forwards a clean sample stream with its own valid strobe.

---
 rtl/cic_rate_ctrl_if.sv | 31 +++
 rtl/cic_rate_ctrl.sv | 128 ++++++++++++
 tb/tb_cic_rate_ctrl.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cic_rate_ctrl_if.sv
// rtl/cic_rate_ctrl_if.sv - rate request handshake and forwarded sample stream of cic_rate_ctrl
interface cic_rate_ctrl_if #(
    parameter int OUT_WIDTH = 18
);
    logic [5:0]                  req_decimation;
    logic                        req_valid;
    logic                        req_ready;
    logic                        req_clamped;
    logic                        out_strobe;
    logic signed [OUT_WIDTH-1:0] out_data;

    // Requester side: issues rate requests, consumes the clean sample stream
    modport master (
        output req_decimation,
        output req_valid,
        input  req_ready,
        input  req_clamped,
        input  out_strobe,
        input  out_data
    );

    // Controller side
    modport slave (
        input  req_decimation,
        input  req_valid,
        output req_ready,
        output req_clamped,
        output out_strobe,
        output out_data
    );
endinterface

// File: rtl/cic_rate_ctrl.sv
// rtl/cic_rate_ctrl.sv - run-time decimation controller for one cic instance
module cic_rate_ctrl #(
    parameter int STAGES             = 5,
    parameter int MIN_DECIMATION     = 2,
    parameter int MAX_DECIMATION     = 40,
    parameter int DEFAULT_DECIMATION = 40,
    parameter int FLUSH_SAMPLES      = 6,
    parameter int DATA_LAG           = 2,
    parameter int OUT_WIDTH          = 18
) (
    input  logic                        clock,
    input  logic                        reset,
    cic_rate_ctrl_if.slave              ctrl,
    output logic [5:0]                  cic_decimation,
    input  logic                        cic_out_strobe,
    input  logic signed [OUT_WIDTH-1:0] cic_out_data,
    output logic                        busy
);

    // The flush counter is sized for the comb-chain settling depth even if
    // FLUSH_SAMPLES is tuned below it, so raising it never needs a resize.
    localparam int FLUSH_MAX = (FLUSH_SAMPLES > STAGES + 1) ? FLUSH_SAMPLES : STAGES + 1;
    localparam int CNT_W     = $clog2(FLUSH_MAX + 1);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_FLUSH = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t                 state;
    logic [5:0]             pending;
    logic [CNT_W-1:0]       flush_cnt;
    logic                   clamped_q;
    logic [5:0]             dec_delta;
    logic [5:0]             req_value;
    logic                   req_low;
    logic                   req_high;
    logic                   transfer;
    logic                   keep_in;
    logic [DATA_LAG-1:0]    keep_sr;
    logic                   out_strobe_q;
    logic signed [OUT_WIDTH-1:0] out_data_q;

    // The applied rate is held relative to DEFAULT_DECIMATION: it is never
    // reset (the CIC phase counter is not either), and an all-zero power-up
    // register then presents the default rate to the CIC.
    assign cic_decimation   = dec_delta ^ 6'(DEFAULT_DECIMATION);

    assign ctrl.req_ready   = (state == S_RUN);
    assign busy             = (state != S_RUN);
    assign ctrl.req_clamped = clamped_q;
    assign ctrl.out_strobe  = out_strobe_q;
    assign ctrl.out_data    = out_data_q;

    assign transfer = ctrl.req_valid && (state == S_RUN);
    assign keep_in  = cic_out_strobe && (state != S_FLUSH);

    // Clamp the requested rate into the legal range
    always_comb begin
        req_low   = (ctrl.req_decimation < 6'(MIN_DECIMATION));
        req_high  = (ctrl.req_decimation > 6'(MAX_DECIMATION));
        req_value = ctrl.req_decimation;
        if (req_low) begin
            req_value = 6'(MIN_DECIMATION);
        end else if (req_high) begin
            req_value = 6'(MAX_DECIMATION);
        end
    end

    // Rate FSM: accept in RUN, apply on the next output boundary, then flush
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_WAIT;
            pending   <= 6'(DEFAULT_DECIMATION);
            flush_cnt <= '0;
            clamped_q <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (transfer) begin
                        clamped_q <= req_low || req_high;
                        if (req_value != cic_decimation) begin
                            pending <= req_value;
                            state   <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cic_out_strobe) begin
                        dec_delta <= pending ^ 6'(DEFAULT_DECIMATION);
                        if ((pending == cic_decimation) || (FLUSH_SAMPLES == 0)) begin
                            state <= S_RUN;
                        end else begin
                            flush_cnt <= CNT_W'(FLUSH_SAMPLES);
                            state     <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (cic_out_strobe) begin
                        flush_cnt <= flush_cnt - CNT_W'(1);
                        if (flush_cnt == CNT_W'(1)) begin
                            state <= S_RUN;
                        end
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

    // Delay keep tags until the CIC data catches up, then forward kept samples
    always_ff @(posedge clock) begin
        if (reset) begin
            keep_sr      <= '0;
            out_strobe_q <= 1'b0;
            out_data_q   <= '0;
        end else begin
            keep_sr      <= DATA_LAG'({keep_sr, keep_in});
            out_strobe_q <= keep_sr[DATA_LAG-1];
            if (keep_sr[DATA_LAG-1]) begin
                out_data_q <= cic_out_data;
            end
        end
    end

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// tb/tb_cic_rate_ctrl.sv - self-checking bench for cic_rate_ctrl
module tb_cic_rate_ctrl;

    localparam int OW      = 18;
    localparam int DEF_DEC = 40;
    localparam int MIN_DEC = 2;
    localparam int MAX_DEC = 40;
    localparam int FLUSH_N = 6;
    localparam int M_RUN   = 0;
    localparam int M_WAIT  = 1;
    localparam int M_FLUSH = 2;
    localparam int LIM     = 3000;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 cic_out_strobe = 1'b0;
    logic signed [OW-1:0] cic_out_data = '0;
    logic [5:0]           cic_decimation;
    logic                 busy;

    cic_rate_ctrl_if #(.OUT_WIDTH(OW)) ctrl ();

    cic_rate_ctrl #(
        .STAGES(5), .MIN_DECIMATION(MIN_DEC), .MAX_DECIMATION(MAX_DEC),
        .DEFAULT_DECIMATION(DEF_DEC), .FLUSH_SAMPLES(FLUSH_N), .DATA_LAG(2), .OUT_WIDTH(OW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ctrl(ctrl),
        .cic_decimation(cic_decimation),
        .cic_out_strobe(cic_out_strobe),
        .cic_out_data(cic_out_data),
        .busy(busy)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // CIC emulation: random input strobes, phase counter against the applied rate
    int                   ph = 0;
    bit                   env_en = 1'b1;
    int                   density = 100;
    bit                   v1 = 1'b0, v2 = 1'b0;
    logic signed [OW-1:0] s1 = '0, s2 = '0;

    initial forever begin
        @(negedge clock);
        if (v2) cic_out_data = s2;
        v2 = v1;
        s2 = s1;
        cic_out_strobe = 1'b0;
        if (env_en && int'($urandom_range(0, 99)) < density) begin
            if (ph >= int'(cic_decimation) - 1) begin
                ph = 0;
                cic_out_strobe = 1'b1;
            end else begin
                ph = ph + 1;
            end
        end
        v1 = cic_out_strobe;
        s1 = OW'($urandom);
    end

    // Reference model: per-strobe keep/drop decisions and a queue of due outputs
    typedef struct { int due; logic signed [OW-1:0] d; } exp_t;
    exp_t                 exp_q[$];
    int                   cyc = 0;
    int                   m_mode = M_WAIT;
    int                   m_dec = DEF_DEC;
    int                   m_pending = DEF_DEC;
    int                   m_drops = 0;
    bit                   m_clamped = 1'b0;
    bit                   m_out_strobe = 1'b0;
    logic signed [OW-1:0] m_out_data = '0;

    initial forever begin : model
        int req_v;
        int cl_v;
        @(posedge clock);
        cyc++;
        if (reset) begin
            m_mode = M_WAIT;
            m_pending = DEF_DEC;
            m_drops = 0;
            m_clamped = 1'b0;
            m_out_strobe = 1'b0;
            m_out_data = '0;
            exp_q.delete();
        end else begin
            m_out_strobe = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                m_out_strobe = 1'b1;
                m_out_data = exp_q[0].d;
                void'(exp_q.pop_front());
            end
            if (cic_out_strobe && m_mode != M_FLUSH) exp_q.push_back('{due: cyc + 2, d: s1});
            case (m_mode)
                M_RUN: if (ctrl.req_valid) begin
                    req_v = int'(ctrl.req_decimation);
                    cl_v = (req_v < MIN_DEC) ? MIN_DEC : ((req_v > MAX_DEC) ? MAX_DEC : req_v);
                    m_clamped = (cl_v != req_v);
                    if (cl_v != m_dec) begin
                        m_pending = cl_v;
                        m_mode = M_WAIT;
                    end
                end
                M_WAIT: if (cic_out_strobe) begin
                    if (m_pending == m_dec) m_mode = M_RUN;
                    else begin
                        m_drops = FLUSH_N;
                        m_mode = M_FLUSH;
                    end
                    m_dec = m_pending;
                end
                default: if (cic_out_strobe) begin
                    m_drops--;
                    if (m_drops == 0) m_mode = M_RUN;
                end
            endcase
        end
    end

    function automatic logic [27:0] obs();
        return {busy, ctrl.req_ready, ctrl.req_clamped, cic_decimation, ctrl.out_strobe, ctrl.out_data};
    endfunction

    function automatic logic [27:0] expv();
        return {m_mode != M_RUN, m_mode == M_RUN, m_clamped, 6'(m_dec), m_out_strobe, m_out_data};
    endfunction

    // Called at negedge+1 in a cycle where req_ready is high; returns one cycle later
    task automatic pulse_req(input logic [5:0] v);
        ctrl.req_decimation = v;
        ctrl.req_valid = 1'b1;
        @(negedge clock);
        #1;
        ctrl.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(negedge clock);
        n_cmp++;
        if ({busy, ctrl.req_ready, ctrl.req_clamped, ctrl.out_strobe, ctrl.out_data, cic_decimation}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 18'd0, 6'd40}) begin
            n_bad++;
            $display("FAIL reset_values got=%b/%b/%b/%b/%0d/%0d want 1/0/0/0/0/40",
                     busy, ctrl.req_ready, ctrl.req_clamped, ctrl.out_strobe, ctrl.out_data, cic_decimation);
        end
        #1 reset = 1'b0;
    endtask

    task automatic test_power_up();
        int k = 0;
        density = 100;
        while (busy && k < 200) begin
            @(negedge clock);
            n_cmp++;
            if (obs() !== expv()) begin n_bad++; $display("FAIL power_up cyc=%0d got=%h want=%h", cyc, obs(), expv()); end
            k++;
        end
        n_cmp++;
        if ({busy, cic_decimation} !== {1'b0, 6'd40}) begin
            n_bad++;
            $display("FAIL power_up_run busy=%b dec=%0d want 0/40", busy, cic_decimation);
        end
        repeat (120) begin
            @(negedge clock);
            n_cmp++;
            if (obs() !== expv()) begin n_bad++; $display("FAIL power_up_fwd cyc=%0d got=%h want=%h", cyc, obs(), expv()); end
        end
    endtask

    task automatic test_rate_change();
        int k = 0;
        int drops = 0;
        repeat (13) begin
            @(negedge clock);
            n_cmp++;
            if (obs() !== expv()) begin n_bad++; $display("FAIL rate_pre cyc=%0d got=%h want=%h", cyc, obs(), expv()); end
        end
        #1;
        pulse_req(6'd10);
        while (busy && k < LIM) begin
            @(negedge clock);
            n_cmp++;
            if (obs() !== expv()) begin n_bad++; $display("FAIL rate_change cyc=%0d got=%h want=%h", cyc, obs(), expv()); end
            k++;
            if (busy) begin
                #1;
                if (cic_decimation == 6'd10 && cic_out_strobe) drops++;
            end
        end
        n_cmp++;
        if ({busy, ctrl.req_ready, cic_decimation} !== {1'b0, 1'b1, 6'd10}) begin
            n_bad++;
            $display("FAIL rate_change_end busy=%b ready=%b dec=%0d want 0/1/10", busy, ctrl.req_ready, cic_decimation);
        end
        n_cmp++;
        if (drops != FLUSH_N) begin n_bad++; $display("FAIL rate_change_drops got=%0d want=%0d", drops, FLUSH_N); end
    endtask

    task automatic test_clamping();
        logic [5:0] req_t[3] = '{6'd1, 6'd63, 6'd20};
        logic [5:0] dec_t[3] = '{6'd2, 6'd40, 6'd20};
        logic       cl_t[3]  = '{1'b1, 1'b1, 1'b0};
        density = 70;
        for (int i = 0; i < 3; i++) begin
            int k = 0;
            #1;
            pulse_req(req_t[i]);
            while (busy && k < LIM) begin
                @(negedge clock);
                n_cmp++;
                if (obs() !== expv()) begin n_bad++; $display("FAIL clamp cyc=%0d got=%h want=%h", cyc, obs(), expv()); end
                k++;
            end
            n_cmp++;
            if ({busy, cic_decimation, ctrl.req_clamped} !== {1'b0, dec_t[i], cl_t[i]}) begin
                n_bad++;
                $display("FAIL clamp_%0d busy=%b dec=%0d clamped=%b want 0/%0d/%b",
                         req_t[i], busy, cic_decimation, ctrl.req_clamped, dec_t[i], cl_t[i]);
            end
        end
    endtask

    task automatic test_same_rate();
        bit any_busy = 1'b0;
        density = 100;
        #1;
        pulse_req(6'd20);
        any_busy = busy;
        repeat (60) begin
            @(negedge clock);
            n_cmp++;
            if (obs() !== expv()) begin n_bad++; $display("FAIL same_rate cyc=%0d got=%h want=%h", cyc, obs(), expv()); end
            any_busy |= busy;
        end
        n_cmp++;
        if ({any_busy, ctrl.req_clamped, cic_decimation} !== {1'b0, 1'b0, 6'd20}) begin
            n_bad++;
            $display("FAIL same_rate_busy busy_seen=%b clamped=%b dec=%0d want 0/0/20", any_busy, ctrl.req_clamped, cic_decimation);
        end
    endtask

    task automatic test_simultaneous();
        int k = 0;
        density = 100;
        @(negedge clock);
        #1;
        while (!(cic_out_strobe && ctrl.req_ready) && k < 200) begin
            @(negedge clock);
            #1;
            k++;
        end
        n_cmp++;
        if (!(cic_out_strobe && ctrl.req_ready)) begin
            n_bad++;
            $display("FAIL simul_search strobe=%b ready=%b want 1/1", cic_out_strobe, ctrl.req_ready);
        end
        pulse_req(6'd8);
        n_cmp++;
        if ({busy, cic_decimation} !== {1'b1, 6'd20}) begin
            n_bad++;
            $display("FAIL simul_not_early busy=%b dec=%0d want 1/20", busy, cic_decimation);
        end
        ctrl.req_decimation = 6'd30;
        ctrl.req_valid = 1'b1;
        k = 0;
        while (busy && k < LIM) begin
            @(negedge clock);
            n_cmp++;
            if (obs() !== expv()) begin n_bad++; $display("FAIL simul_held cyc=%0d got=%h want=%h", cyc, obs(), expv()); end
            k++;
        end
        n_cmp++;
        if ({busy, cic_decimation} !== {1'b0, 6'd8}) begin
            n_bad++;
            $display("FAIL simul_applied busy=%b dec=%0d want 0/8", busy, cic_decimation);
        end
        @(negedge clock);
        #1;
        ctrl.req_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL simul_held_accept busy=%b want 1", busy); end
        k = 0;
        while (busy && k < LIM) begin
            @(negedge clock);
            n_cmp++;
            if (obs() !== expv()) begin n_bad++; $display("FAIL simul_second cyc=%0d got=%h want=%h", cyc, obs(), expv()); end
            k++;
        end
        n_cmp++;
        if ({busy, cic_decimation} !== {1'b0, 6'd30}) begin
            n_bad++;
            $display("FAIL simul_second_end busy=%b dec=%0d want 0/30", busy, cic_decimation);
        end
    endtask

    task automatic test_stall();
        int k = 0;
        #1;
        env_en = 1'b0;
        pulse_req(6'd12);
        repeat (80) begin
            @(negedge clock);
            n_cmp++;
            if (obs() !== expv()) begin n_bad++; $display("FAIL stall cyc=%0d got=%h want=%h", cyc, obs(), expv()); end
        end
        n_cmp++;
        if ({busy, cic_decimation} !== {1'b1, 6'd30}) begin
            n_bad++;
            $display("FAIL stall_hold busy=%b dec=%0d want 1/30", busy, cic_decimation);
        end
        env_en = 1'b1;
        while (busy && k < LIM) begin
            @(negedge clock);
            n_cmp++;
            if (obs() !== expv()) begin n_bad++; $display("FAIL stall_resume cyc=%0d got=%h want=%h", cyc, obs(), expv()); end
            k++;
        end
        n_cmp++;
        if ({busy, cic_decimation} !== {1'b0, 6'd12}) begin
            n_bad++;
            $display("FAIL stall_end busy=%b dec=%0d want 0/12", busy, cic_decimation);
        end
    endtask

    task automatic test_reset_mid_flush();
        int k = 0;
        int seen = 0;
        int drops = 0;
        density = 100;
        #1;
        pulse_req(6'd10);
        while (seen < 4 && k < LIM) begin
            @(negedge clock);
            n_cmp++;
            if (obs() !== expv()) begin n_bad++; $display("FAIL rmf_pre cyc=%0d got=%h want=%h", cyc, obs(), expv()); end
            #1;
            if (cic_decimation == 6'd10 && cic_out_strobe) seen++;
            k++;
        end
        reset = 1'b1;
        repeat (2) begin
            @(negedge clock);
            n_cmp++;
            if (obs() !== expv()) begin n_bad++; $display("FAIL rmf_reset cyc=%0d got=%h want=%h", cyc, obs(), expv()); end
        end
        #1 reset = 1'b0;
        n_cmp++;
        if ({busy, ctrl.out_strobe, cic_decimation} !== {1'b1, 1'b0, 6'd10}) begin
            n_bad++;
            $display("FAIL rmf_after_reset busy=%b strobe=%b dec=%0d want 1/0/10", busy, ctrl.out_strobe, cic_decimation);
        end
        k = 0;
        while (busy && k < LIM) begin
            @(negedge clock);
            n_cmp++;
            if (obs() !== expv()) begin n_bad++; $display("FAIL rmf_recover cyc=%0d got=%h want=%h", cyc, obs(), expv()); end
            k++;
            if (busy) begin
                #1;
                if (cic_decimation == 6'd40 && cic_out_strobe) drops++;
            end
        end
        n_cmp++;
        if ({busy, cic_decimation} !== {1'b0, 6'd40}) begin
            n_bad++;
            $display("FAIL rmf_end busy=%b dec=%0d want 0/40", busy, cic_decimation);
        end
        n_cmp++;
        if (drops != FLUSH_N) begin n_bad++; $display("FAIL rmf_drops got=%0d want=%0d", drops, FLUSH_N); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 15; i++) begin
            int k = 0;
            density = int'($urandom_range(30, 100));
            repeat (int'($urandom_range(0, 20))) begin
                @(negedge clock);
                n_cmp++;
                if (obs() !== expv()) begin n_bad++; $display("FAIL random_idle cyc=%0d got=%h want=%h", cyc, obs(), expv()); end
            end
            #1;
            pulse_req(6'($urandom_range(0, 63)));
            while (busy && k < LIM) begin
                @(negedge clock);
                n_cmp++;
                if (obs() !== expv()) begin n_bad++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs(), expv()); end
                k++;
            end
            n_cmp++;
            if (busy !== 1'b0) begin n_bad++; $display("FAIL random_timeout busy=%b want 0", busy); end
        end
    endtask

    initial begin
        ctrl.req_valid = 1'b0;
        ctrl.req_decimation = 6'd0;
        test_reset();
        test_power_up();
        test_rate_change();
        test_clamping();
        test_same_rate();
        test_simultaneous();
        test_stall();
        test_reset_mid_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
